// File: rtl/column_count_accumulator.sv
// column_count_accumulator: sums 4-bit column counts over a frame closed by in_last or a beat limit,
// presenting the saturating total on a valid/ready output register.
module column_count_accumulator #(
    parameter int ACC_W     = 10,
    parameter int MAX_BEATS = 64,
    parameter int CNT_W     = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_cnt,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_beats,
    output logic             out_sat,
    output logic             out_trunc
);
    typedef enum logic {IDLE, ACCUM} state_t;

    state_t           state, state_next;
    logic [ACC_W-1:0] acc, nsum;
    logic [ACC_W:0]   wsum;
    logic [CNT_W-1:0] beats, nbeats;
    logic             sat, sat_next, accept, close;

    // A pop in the same cycle frees the output register, so there is no bubble.
    assign in_ready = ~out_valid | out_ready;

    always_comb begin
        accept     = in_valid & in_ready;
        wsum       = {1'b0, acc} + (ACC_W+1)'(in_cnt);
        nsum       = wsum[ACC_W] ? '1 : wsum[ACC_W-1:0];
        sat_next   = sat | wsum[ACC_W];
        nbeats     = beats + 1'b1;
        close      = accept & (in_last | (nbeats == CNT_W'(MAX_BEATS)));
        state_next = accept ? (close ? IDLE : ACCUM) : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            beats <= '0;
            sat   <= 1'b0;
        end else begin
            state <= state_next;
            if (close) begin
                acc   <= '0;
                beats <= '0;
                sat   <= 1'b0;
            end else if (accept) begin
                acc   <= nsum;
                beats <= nbeats;
                sat   <= sat_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_beats <= '0;
            out_sat   <= 1'b0;
            out_trunc <= 1'b0;
        end else if (close) begin
            out_valid <= 1'b1;
            out_sum   <= nsum;
            out_beats <= nbeats;
            out_sat   <= sat_next;
            out_trunc <= ~in_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_column_count_accumulator.sv
// tb_column_count_accumulator: directed scenario tasks for the frame accumulator,
// with a narrow-ACC_W instance sharing the inputs for the saturation case.
module tb_column_count_accumulator;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_cnt = 4'd0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b1;

    logic       in_ready, out_valid, out_sat, out_trunc;
    logic [9:0] out_sum;
    logic [6:0] out_beats;
    logic       in_ready6, out_valid6, out_sat6, out_trunc6;
    logic [5:0] out_sum6;
    logic [6:0] out_beats6;

    int n_checks = 0;
    int n_fail   = 0;

    column_count_accumulator dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_cnt(in_cnt),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_beats(out_beats), .out_sat(out_sat), .out_trunc(out_trunc)
    );

    column_count_accumulator #(.ACC_W(6)) dut6 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready6), .in_cnt(in_cnt),
        .in_last(in_last), .out_valid(out_valid6), .out_ready(out_ready), .out_sum(out_sum6),
        .out_beats(out_beats6), .out_sat(out_sat6), .out_trunc(out_trunc6)
    );

    always #5 clk = ~clk;

    // Result vector: {valid, sum, beats, sat, trunc}
    wire [19:0] res  = {out_valid, out_sum, out_beats, out_sat, out_trunc};
    wire [15:0] res6 = {out_valid6, out_sum6, out_beats6, out_sat6, out_trunc6};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [3:0] c, input logic l);
        in_valid = 1'b1;
        in_cnt   = c;
        in_last  = l;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        n_checks++;
        if (res !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected %h", res, 20'h0);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [3:0] c[4] = '{4'd3, 4'd15, 4'd0, 4'd7};
        for (int i = 0; i < 3; i++) beat(c[i], 1'b0);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_no_early_valid: got %b expected 0", out_valid);
        end
        beat(c[3], 1'b1);
        n_checks++;
        if (res !== {1'b1, 10'd25, 7'd4, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_frame: got %h expected %h", res, {1'b1, 10'd25, 7'd4, 1'b0, 1'b0});
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pop: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_trunc;
        for (int i = 0; i < 63; i++) beat(4'd15, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL trunc_early: got %b expected 0", out_valid);
        end
        beat(4'd15, 1'b0);
        n_checks++;
        if (res !== {1'b1, 10'd960, 7'd64, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL trunc_frame: got %h expected %h", res, {1'b1, 10'd960, 7'd64, 1'b0, 1'b1});
        end
        beat(4'd4, 1'b1);
        n_checks++;
        if (res !== {1'b1, 10'd4, 7'd1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL trunc_fresh_frame: got %h expected %h", res, {1'b1, 10'd4, 7'd1, 1'b0, 1'b0});
        end
        tick();
    endtask

    task automatic test_sat;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) beat(4'd15, 1'b0);
        beat(4'd15, 1'b1);
        n_checks++;
        if (res6 !== {1'b1, 6'd63, 7'd5, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL sat_narrow: got %h expected %h", res6, {1'b1, 6'd63, 7'd5, 1'b1, 1'b0});
        end
        n_checks++;
        if (res !== {1'b1, 10'd75, 7'd5, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL sat_wide_no_sat: got %h expected %h", res, {1'b1, 10'd75, 7'd5, 1'b0, 1'b0});
        end
        beat(4'd2, 1'b1);
        n_checks++;
        if (res6 !== {1'b1, 6'd2, 7'd1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL sat_not_sticky: got %h expected %h", res6, {1'b1, 6'd2, 7'd1, 1'b0, 1'b0});
        end
        tick();
    endtask

    task automatic test_stall;
        out_ready = 1'b0;
        beat(4'd6, 1'b1);
        in_valid = 1'b1;
        in_cnt   = 4'd5;
        in_last  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (in_ready !== 1'b0 || res !== {1'b1, 10'd6, 7'd1, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL stall_hold cycle %0d: in_ready %b res %h expected 0 %h", i, in_ready, res,
                         {1'b1, 10'd6, 7'd1, 1'b0, 1'b0});
            end
            tick();
        end
        out_ready = 1'b1;
        in_cnt    = 4'd9;
        in_last   = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release_ready: got %b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        n_checks++;
        if (res !== {1'b1, 10'd9, 7'd1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL stall_pop_reload: got %h expected %h", res, {1'b1, 10'd9, 7'd1, 1'b0, 1'b0});
        end
        tick();
    endtask

    task automatic test_back_to_back;
        for (int i = 1; i <= 15; i++) begin
            beat(4'(i), 1'b1);
            in_valid = (i < 15);
            n_checks++;
            if (res !== {1'b1, 10'(i), 7'd1, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL back_to_back %0d: got %h expected %h", i, res, {1'b1, 10'(i), 7'd1, 1'b0, 1'b0});
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 3; i++) beat(4'd2, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (res !== 20'h0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_rst_midframe: got %h/%b expected 0/1", res, in_ready);
        end
        rst = 1'b0;
        tick();
        beat(4'd5, 1'b1);
        n_checks++;
        if (res !== {1'b1, 10'd5, 7'd1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_rst_next_frame: got %h expected %h", res, {1'b1, 10'd5, 7'd1, 1'b0, 1'b0});
        end
        out_ready = 1'b0;
        beat(4'd7, 1'b0);
        tick();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (res !== 20'h0) begin
            n_fail++;
            $display("FAIL async_rst_pending: got %h expected 0", res);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        beat(4'd5, 1'b1);
        n_checks++;
        if (res !== {1'b1, 10'd5, 7'd1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_rst_after_pending: got %h expected %h", res, {1'b1, 10'd5, 7'd1, 1'b0, 1'b0});
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_trunc();
        test_sat();
        test_stall();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
